pc_jump_ctrl: RTL

- Drives the 2-bit jump select of the next-PC multiplexer and the two jump-target inputs it chooses between.
- Registers the multiplexer's 32-bit result as the program counter.
- Decodes J, JAL and JR from the fetched instruction and waits for a valid JR source register.
- Issues a fetch flush after every taken jump and latches the link address for JAL.

---
 rtl/pc_jump_ctrl_pkg.sv | 26 ++
 rtl/pc_jump_ctrl_decode.sv | 25 ++
 rtl/pc_jump_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pc_jump_ctrl_pkg.sv
// Package pc_ctrl_defs: shared constants and types for the jump/PC control.
//   - MIPS opcode/funct values for J, JAL and JR decode
//   - next-PC mux select encodings
//   - control FSM state encoding
// Bit-numbering note: the instruction set documents bit 0 as the MSB. All
// vectors here are declared [31:0] with bit 31 as the MSB, so documented
// bits [0:5] are [31:26] here, [26:31] are [5:0], and so on.
package pc_ctrl_defs;

  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] SEL_JUMP = 2'b00;
  localparam logic [1:0] SEL_SEQ  = 2'b01;
  localparam logic [1:0] SEL_JR   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_JR_WAIT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_ERR     = 2'd3
  } state_e;

endpackage

// File: rtl/pc_jump_ctrl_decode.sv
// jump_decode: purely combinational instruction classifier.
// Ports:
//   instr       in  32  fetched instruction ([31:26] opcode, [5:0] funct)
//   pc_hi       in  4   upper nibble of pc + 4 (region kept by J/JAL)
//   is_j        out 1   instruction is J
//   is_jal      out 1   instruction is JAL
//   is_jr       out 1   instruction is JR
//   jump_target out 32  {pc_hi, instr[25:0], 2'b00}
module jump_decode
  import pc_ctrl_defs::*;
(
  input  logic [31:0] instr,
  input  logic [3:0]  pc_hi,
  output logic        is_j,
  output logic        is_jal,
  output logic        is_jr,
  output logic [31:0] jump_target
);

  assign is_j        = (instr[31:26] == OP_J);
  assign is_jal      = (instr[31:26] == OP_JAL);
  assign is_jr       = (instr[31:26] == OP_RTYPE) && (instr[5:0] == FN_JR);
  assign jump_target = {pc_hi, instr[25:0], 2'b00};

endmodule

// File: rtl/pc_jump_ctrl.sv
// pc_jump_ctrl: PC register plus control FSM for J / JAL / JR.
// Ports:
//   clk, reset   in      clock (rising) and async active-high reset
//   instr        in  32  fetched instruction
//   instr_valid  in  1   instr is a new instruction this cycle
//   stall        in  1   freezes PC, FSM, flush counter; kills link_we
//   rs_data      in  32  rs value, JR target
//   rs_valid     in  1   rs_data is hazard-free
//   pc_next_in   in  32  next-PC mux output, loaded into pc when pc_we
//   jump_sel     out 2   mux select: 00 jump, 01 sequential, 10 JR
//   jump_target  out 32  J/JAL target (mux input 00)
//   jr_target    out 32  rs_data pass-through (mux input 10)
//   pc           out 32  program counter
//   pc_plus4     out 32  pc + 4 (mod 2^32)
//   flush        out 1   high while in FLUSH
//   link_we      out 1   $31 write strobe in the JAL decode cycle
//   link_addr    out 32  pc_plus4 captured at the JAL decode
//   addr_err     out 1   sticky misaligned-JR flag
// Handshake: instr is consumed only in a cycle where instr_valid=1, the FSM
// is in RUN and stall=0; there is no back-pressure signal, a stalled or
// ignored instruction must be re-presented by the fetch stage.
// The FSM state is available to checkers as the internal signal 'state'.
module pc_jump_ctrl
  import pc_ctrl_defs::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic [31:0] rs_data,
  input  logic        rs_valid,
  input  logic [31:0] pc_next_in,
  output logic [1:0]  jump_sel,
  output logic [31:0] jump_target,
  output logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        addr_err
);

  localparam logic [1:0] FC = FLUSH_CYCLES[1:0];

  state_e      state, state_d;
  logic [1:0]  cnt, cnt_d;
  logic        pc_we;
  logic        err_set;
  logic        is_j, is_jal, is_jr;
  logic        jr_ok, jr_bad;

  jump_decode u_decode (
    .instr       (instr),
    .pc_hi       (pc_plus4[31:28]),
    .is_j        (is_j),
    .is_jal      (is_jal),
    .is_jr       (is_jr),
    .jump_target (jump_target)
  );

  assign pc_plus4  = pc + 32'd4;
  assign jr_target = rs_data;
  assign flush     = (state == ST_FLUSH);

  // A JR resolves only once rs is hazard-free; the low two bits decide
  // between taking the jump and trapping into ERR.
  assign jr_ok  = rs_valid && (rs_data[1:0] == 2'b00);
  assign jr_bad = rs_valid && (rs_data[1:0] != 2'b00);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    pc_we    = 1'b0;
    jump_sel = SEL_SEQ;
    link_we  = 1'b0;
    err_set  = 1'b0;
    case (state)
      ST_RUN: begin
        if (instr_valid) begin
          if (is_j || is_jal) begin
            jump_sel = SEL_JUMP;
            pc_we    = 1'b1;
            state_d  = ST_FLUSH;
            cnt_d    = FC;
            link_we  = is_jal;
          end else if (is_jr) begin
            if (jr_ok) begin
              jump_sel = SEL_JR;
              pc_we    = 1'b1;
              state_d  = ST_FLUSH;
              cnt_d    = FC;
            end else if (jr_bad) begin
              err_set = 1'b1;
              state_d = ST_ERR;
            end else begin
              state_d = ST_JR_WAIT;
            end
          end else begin
            pc_we = 1'b1;
          end
        end
      end
      ST_JR_WAIT: begin
        if (jr_ok) begin
          jump_sel = SEL_JR;
          pc_we    = 1'b1;
          state_d  = ST_FLUSH;
          cnt_d    = FC;
        end else if (jr_bad) begin
          err_set = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_FLUSH: begin
        // cnt holds the flush cycles remaining including this one.
        if (cnt <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt - 2'd1;
        end
      end
      default: ;  // ST_ERR: frozen until reset
    endcase
    // Stall wins over everything: nothing advances and no strobe escapes.
    if (stall) begin
      state_d = state;
      cnt_d   = cnt;
      pc_we   = 1'b0;
      link_we = 1'b0;
      err_set = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      cnt       <= 2'd0;
      pc        <= RESET_PC;
      link_addr <= 32'd0;
      addr_err  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (pc_we)   pc        <= pc_next_in;
      if (link_we) link_addr <= pc_plus4;
      if (err_set) addr_err  <= 1'b1;
    end
  end

endmodule
